// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   - ifu_state_e : fetch FSM state encoding
//   - Redir*      : redir_type codes
//   - ResetPcDefault : default first fetch address after reset
package ifu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFull,
    StDrain
  } ifu_state_e;

  localparam logic [1:0] RedirBranch = 2'b00;
  localparam logic [1:0] RedirJump   = 2'b01;
  localparam logic [1:0] RedirJr     = 2'b10;
  localparam logic [1:0] RedirRsvd   = 2'b11;

  localparam logic [31:0] ResetPcDefault = 32'h0000_3000;

endpackage

// File: rtl/ifu_npc.sv
// ifu_npc: combinational redirect target computation.
// Ports:
//   i_redir_type  - 00 branch, 01 j/jal, 10 jr, 11 reserved
//   i_redir_pc    - PC of the redirecting instruction
//   i_redir_off   - sign-extended branch offset, already shifted left 2
//   i_redir_index - j/jal instr_index field
//   i_redir_reg   - jr register target
//   o_target      - computed fetch target (don't-care for the reserved type)
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [1:0]  i_redir_type,
  input  logic [31:0] i_redir_pc,
  input  logic [31:0] i_redir_off,
  input  logic [25:0] i_redir_index,
  input  logic [31:0] i_redir_reg,
  output logic [31:0] o_target
);

  logic [31:0] w_seq_pc;
  logic        w_unused_reg_lsbs;

  // All additions wrap modulo 2^32.
  assign w_seq_pc = i_redir_pc + 32'd4;

  // jr forces word alignment, so the two low register bits are dropped.
  assign w_unused_reg_lsbs = ^i_redir_reg[1:0];

  always_comb begin
    o_target = w_seq_pc + i_redir_off;
    case (i_redir_type)
      RedirJump: o_target = {w_seq_pc[31:28], i_redir_index, 2'b00};
      RedirJr:   o_target = {i_redir_reg[31:2], 2'b00};
      default:   o_target = w_seq_pc + i_redir_off;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit with a single outstanding memory request and a
// one-entry output buffer towards decode.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   imem_req/addr         - fetch request and word-aligned address (addr is 0 when idle)
//   imem_gnt              - memory accepted the request this cycle
//   imem_rvalid/rdata     - fetch response
//   instr_valid/ready     - handshake with decode
//   instr, instr_pc       - buffered instruction and its address
//   redirect, redir_*     - control-flow change request from decode
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_off,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_reg
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_next;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        w_load;
  logic        w_redir_valid;
  logic [31:0] w_target;

  ifu_npc u_npc (
    .i_redir_type  (redir_type),
    .i_redir_pc    (redir_pc),
    .i_redir_off   (redir_off),
    .i_redir_index (redir_index),
    .i_redir_reg   (redir_reg),
    .o_target      (w_target)
  );

  // The reserved redirect type is a no-op.
  assign w_redir_valid = redirect && (redir_type != RedirRsvd);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_load          = 1'b0;
    case (r_state)
      StIdle: w_state_next = StReq;
      StReq: begin
        // A granted request cannot be withdrawn: drain its response if redirected.
        if (imem_gnt) w_state_next = w_redir_valid ? StDrain : StWait;
      end
      StWait: begin
        if (w_redir_valid) begin
          w_state_next = imem_rvalid ? StReq : StDrain;
        end else if (imem_rvalid) begin
          w_load          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          w_state_next    = StFull;
        end
      end
      StFull: begin
        if (w_redir_valid || instr_ready) w_state_next = StReq;
      end
      StDrain: begin
        // A redirect only retargets fetch_pc here; leaving still waits for rvalid.
        if (imem_rvalid) w_state_next = StReq;
      end
      default: w_state_next = StIdle;
    endcase
    if (w_redir_valid) w_fetch_pc_next = w_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      if (w_load) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_fetch_pc;
      end
    end
  end

  assign imem_req    = (r_state == StReq);
  assign imem_addr   = imem_req ? r_fetch_pc : '0;
  assign instr_valid = (r_state == StFull);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule
